// File: rtl/inst_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package inst_fetch_pkg;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
  localparam logic        RST_ENABLE = 1'b0;
  localparam logic        STOP       = 1'b1;
  localparam logic        NOSTOP     = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } if_state_e;

  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch.sv
// IF stage: issues word fetches on the instruction bus, delivers the returned
// word to if/id, and absorbs IF stalls, branch redirects and exception flushes.
module inst_fetch
  import inst_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_addr_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_ack_i,
  input  logic [31:0] ibus_data_i,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_o
);

  if_state_e   state, state_nx;
  logic [31:0] pc, pc_nx;
  logic        pend_vld, pend_vld_nx;
  logic [31:0] pend_addr, pend_addr_nx;
  logic [31:0] redirect, redirect_nx;
  logic [31:0] hold_inst, hold_nx;

  logic in_rst, deliver, advance;
  logic unused_stall;

  assign unused_stall = ^{stall[5:2], stall[0]};

  // Outputs are forced to their idle values while reset is held so a request
  // in flight is dropped in the same cycle reset is seen.
  assign in_rst     = (rst == RST_ENABLE);
  assign deliver    = !in_rst && !flush &&
                      (((state == FETCH) && ibus_ack_i) || (state == HOLD));
  assign advance    = deliver && (stall[1] == NOSTOP);
  assign ibus_req_o = !in_rst && ((state == FETCH) || (state == DRAIN));
  assign ibus_addr_o = ibus_req_o ? word_addr(pc) : ZERO_WORD;
  assign if_pc      = deliver ? pc : ZERO_WORD;
  assign if_inst    = deliver ? (ibus_ack_i ? ibus_data_i : hold_inst) : ZERO_WORD;
  assign stallreq_o = in_rst || (!deliver && !flush);

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      pend_vld  <= 1'b0;
      pend_addr <= ZERO_WORD;
      redirect  <= ZERO_WORD;
      hold_inst <= ZERO_WORD;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      pend_vld  <= pend_vld_nx;
      pend_addr <= pend_addr_nx;
      redirect  <= redirect_nx;
      hold_inst <= hold_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    pc_nx        = pc;
    pend_vld_nx  = pend_vld;
    pend_addr_nx = pend_addr;
    redirect_nx  = redirect;
    hold_nx      = hold_inst;

    // A live branch is newer than a pending one, so it wins the redirect.
    if (advance) begin
      if (branch_flag_i)  pc_nx = branch_target_addr_i;
      else if (pend_vld)  pc_nx = pend_addr;
      else                pc_nx = pc + 32'd4;
      pend_vld_nx = 1'b0;
      state_nx    = FETCH;
    end else if (branch_flag_i && (state != DRAIN) && !flush) begin
      pend_vld_nx  = 1'b1;
      pend_addr_nx = branch_target_addr_i;
    end

    case (state)
      IDLE: begin
        state_nx = FETCH;
        if (flush) begin
          pc_nx       = new_pc;
          pend_vld_nx = 1'b0;
        end
      end
      FETCH: begin
        if (flush) begin
          pend_vld_nx = 1'b0;
          if (ibus_ack_i) begin
            pc_nx   = new_pc;
            hold_nx = ZERO_WORD;
          end else begin
            redirect_nx = new_pc;
            state_nx    = DRAIN;
          end
        end else if (ibus_ack_i && !advance) begin
          hold_nx  = ibus_data_i;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (flush) begin
          pc_nx       = new_pc;
          pend_vld_nx = 1'b0;
          hold_nx     = ZERO_WORD;
          state_nx    = FETCH;
        end
      end
      DRAIN: begin
        // The outstanding word belongs to the squashed path; wait it out.
        if (flush) redirect_nx = new_pc;
        if (ibus_ack_i) begin
          pc_nx    = flush ? new_pc : redirect;
          state_nx = FETCH;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a per-cycle reference model.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  logic [31:0] new_pc = '0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_addr_i = '0;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_ack_i = 1'b0;
  logic [31:0] ibus_data_i = '0;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_o;

  int checks = 0;
  int failures = 0;

  inst_fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .branch_flag_i(branch_flag_i), .branch_target_addr_i(branch_target_addr_i),
    .ibus_req_o(ibus_req_o), .ibus_addr_o(ibus_addr_o), .ibus_ack_i(ibus_ack_i),
    .ibus_data_i(ibus_data_i), .if_pc(if_pc), .if_inst(if_inst), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: "where the fetch unit is" in plain terms.
  // mode 0 = starting up, 1 = waiting on word, 2 = parked on a word, 3 = squashing a word
  int          m_mode = 0;
  logic [31:0] m_pc = 0;
  bit          m_has_br = 0;
  logic [31:0] m_br = 0;
  logic [31:0] m_redir = 0;
  logic [31:0] m_word = 0;

  function automatic bit m_gives_word();
    return rst && !flush && ((m_mode == 1 && ibus_ack_i) || m_mode == 2);
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_mode <= 0; m_pc <= 0; m_has_br <= 0; m_br <= 0; m_redir <= 0; m_word <= 0;
    end else if (flush && m_mode != 3) begin
      m_has_br <= 0;
      if (m_mode == 1 && !ibus_ack_i) begin
        m_redir <= new_pc; m_mode <= 3;
      end else begin
        m_pc <= new_pc; m_word <= 0; m_mode <= 1;
      end
    end else if (m_mode == 3) begin
      if (flush) m_redir <= new_pc;
      if (ibus_ack_i) begin
        m_pc <= flush ? new_pc : m_redir; m_mode <= 1;
      end
    end else if (m_gives_word() && !stall[1]) begin
      m_pc <= branch_flag_i ? branch_target_addr_i : (m_has_br ? m_br : m_pc + 4);
      m_has_br <= 0; m_mode <= 1;
    end else begin
      if (branch_flag_i) begin m_has_br <= 1; m_br <= branch_target_addr_i; end
      if (m_mode == 0) m_mode <= 1;
      else if (m_mode == 1 && ibus_ack_i) begin m_word <= ibus_data_i; m_mode <= 2; end
    end
  end

  always @(negedge clk) begin
    bit busy, give;
    busy = rst && (m_mode == 1 || m_mode == 3);
    give = m_gives_word();
    chk("m_req",      {31'd0, ibus_req_o}, {31'd0, busy});
    chk("m_addr",     ibus_addr_o, busy ? (m_pc & 32'hFFFF_FFFC) : 32'd0);
    chk("m_if_pc",    if_pc, give ? m_pc : 32'd0);
    chk("m_if_inst",  if_inst, give ? (ibus_ack_i ? ibus_data_i : m_word) : 32'd0);
    chk("m_stallreq", {31'd0, stallreq_o}, {31'd0, (!rst || (!give && !flush))});
  end

  task automatic go(input logic r, input logic a, input logic [31:0] d, input logic [5:0] st,
                    input logic fl, input logic [31:0] np, input logic br, input logic [31:0] bt);
    @(posedge clk); #1;
    rst = r; ibus_ack_i = a; ibus_data_i = d; stall = st; flush = fl; new_pc = np;
    branch_flag_i = br; branch_target_addr_i = bt;
    @(negedge clk);
  endtask

  initial begin
    // Reset
    go(0, 1, 32'hDEAD, 0, 0, 0, 0, 0);
    go(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_req", {31'd0, ibus_req_o}, 0);
    chk("rst_addr", ibus_addr_o, 0);
    chk("rst_stallreq", {31'd0, stallreq_o}, 1);
    chk("rst_inst", if_inst, 0);
    go(1, 0, 0, 0, 0, 0, 0, 0);
    chk("idle_req", {31'd0, ibus_req_o}, 0);

    // Zero-wait acks: 0x0, 0x4, 0x8
    go(1, 1, 32'hA000_0000, 0, 0, 0, 0, 0);
    chk("a0_addr", ibus_addr_o, 32'h0);
    chk("a0_inst", if_inst, 32'hA000_0000);
    chk("a0_stallreq", {31'd0, stallreq_o}, 0);
    go(1, 1, 32'hA000_0001, 0, 0, 0, 0, 0);
    chk("a4_addr", ibus_addr_o, 32'h4);
    go(1, 1, 32'hA000_0002, 0, 0, 0, 0, 0);
    chk("a8_addr", ibus_addr_o, 32'h8);
    chk("a8_inst", if_inst, 32'hA000_0002);

    // IF stall on ack at 0xC, held three cycles
    go(1, 1, 32'hA000_0003, 6'b000010, 0, 0, 0, 0);
    chk("ac_inst", if_inst, 32'hA000_0003);
    go(1, 0, 0, 6'b000011, 0, 0, 0, 0);
    chk("hold1_req", {31'd0, ibus_req_o}, 0);
    chk("hold1_inst", if_inst, 32'hA000_0003);
    go(1, 0, 0, 6'b000010, 0, 0, 0, 0);
    chk("hold2_pc", if_pc, 32'hC);
    go(1, 0, 0, 0, 0, 0, 0, 0);
    chk("hold3_inst", if_inst, 32'hA000_0003);

    // Branch while request waits
    go(1, 0, 0, 0, 0, 0, 1, 32'h100);
    chk("br_addr", ibus_addr_o, 32'h10);
    chk("br_stallreq", {31'd0, stallreq_o}, 1);
    go(1, 0, 0, 0, 0, 0, 0, 0);
    go(1, 1, 32'hA000_0004, 0, 0, 0, 0, 0);
    chk("br_ack_inst", if_inst, 32'hA000_0004);
    go(1, 1, 32'hA000_0005, 0, 0, 0, 0, 0);
    chk("br_tgt_addr", ibus_addr_o, 32'h100);

    // Flush while 0x104 unacked -> drain
    go(1, 0, 0, 0, 1, 32'h180, 0, 0);
    chk("fl_stallreq", {31'd0, stallreq_o}, 0);
    go(1, 0, 0, 0, 0, 0, 0, 0);
    chk("drain_addr", ibus_addr_o, 32'h104);
    go(1, 1, 32'hBAD0_0006, 0, 0, 0, 0, 0);
    chk("drain_inst", if_inst, 0);
    chk("drain_req", {31'd0, ibus_req_o}, 1);
    go(1, 1, 32'hA000_0007, 0, 0, 0, 0, 0);
    chk("redir_addr", ibus_addr_o, 32'h180);

    // Flush with ack to top of memory, then wrap
    go(1, 1, 32'hBAD0_0008, 0, 1, 32'hFFFF_FFFC, 0, 0);
    chk("flack_inst", if_inst, 0);
    go(1, 1, 32'hA000_0009, 0, 0, 0, 0, 0);
    chk("top_addr", ibus_addr_o, 32'hFFFF_FFFC);
    chk("top_pc", if_pc, 32'hFFFF_FFFC);
    go(1, 0, 0, 0, 0, 0, 0, 0);
    chk("wrap_addr", ibus_addr_o, 32'h0);

    // Branch during hold becomes pending
    go(1, 1, 32'hA000_000A, 6'b000010, 0, 0, 0, 0);
    go(1, 0, 0, 6'b000010, 0, 0, 1, 32'h200);
    chk("hbr_inst", if_inst, 32'hA000_000A);
    go(1, 0, 0, 0, 0, 0, 0, 0);
    go(1, 0, 0, 0, 0, 0, 0, 0);
    chk("hbr_addr", ibus_addr_o, 32'h200);

    // Live branch on advance
    go(1, 1, 32'hA000_000B, 0, 0, 0, 1, 32'h280);
    go(1, 0, 0, 0, 0, 0, 0, 0);
    chk("live_br_addr", ibus_addr_o, 32'h280);

    // Flush in hold
    go(1, 1, 32'hA000_000C, 6'b000010, 0, 0, 0, 0);
    go(1, 0, 0, 6'b000010, 1, 32'h2C0, 0, 0);
    chk("hfl_inst", if_inst, 0);
    go(1, 0, 0, 0, 0, 0, 0, 0);
    chk("hfl_addr", ibus_addr_o, 32'h2C0);

    // Second flush in drain overwrites redirect; branch ignored
    go(1, 0, 0, 0, 1, 32'h300, 0, 0);
    go(1, 0, 0, 0, 1, 32'h340, 0, 0);
    go(1, 0, 0, 0, 0, 0, 1, 32'h400);
    chk("dr2_addr", ibus_addr_o, 32'h2C0);
    go(1, 1, 32'hBAD0_000D, 0, 0, 0, 0, 0);
    go(1, 0, 0, 0, 0, 0, 0, 0);
    chk("dr2_redir", ibus_addr_o, 32'h340);

    // Reset mid-request, then restart at 0
    go(0, 0, 0, 0, 0, 0, 0, 0);
    chk("mrst_req", {31'd0, ibus_req_o}, 0);
    go(1, 0, 0, 0, 0, 0, 0, 0);
    chk("mrst_idle_req", {31'd0, ibus_req_o}, 0);
    go(1, 0, 0, 0, 0, 0, 0, 0);
    chk("mrst_restart", ibus_addr_o, 32'h0);
    chk("mrst_req2", {31'd0, ibus_req_o}, 1);
    go(1, 1, 32'hA000_000E, 0, 0, 0, 0, 0);
    chk("mrst_inst", if_inst, 32'hA000_000E);
    go(1, 0, 0, 0, 0, 0, 0, 0);
    chk("mrst_next", ibus_addr_o, 32'h4);

    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset: synchronous, active-low (`RstEnable` = 0).
REQ-003 SHALL have port stall, input, 6, pipeline stall vector from ctrl; bit 0 is the PC stage, bit 1 is the IF stage.
REQ-004 SHALL have port flush, input, 1, exception flush from ctrl.
REQ-005 SHALL have port new_pc, input, 32, exception redirect address, valid while flush = 1.
REQ-006 SHALL have port branch_flag_i, input, 1, branch taken, from the ID stage.
REQ-007 SHALL have port branch_target_addr_i, input, 32, branch target, valid while branch_flag_i = 1.
REQ-008 SHALL have port ibus_req_o, output, 1, instruction-bus request.
REQ-009 SHALL have port ibus_addr_o, output, 32, fetch address; bits [1:0] always 0.
REQ-010 SHALL have port ibus_ack_i, input, 1, one-cycle response strobe.
REQ-011 SHALL have port ibus_data_i, input, 32, instruction word, valid with ack.
REQ-012 SHALL have port if_pc, output, 32, PC of the delivered instruction; feeds the if/id register.
REQ-013 SHALL have port if_inst, output, 32, delivered instruction; 0 (nop) when nothing is delivered.
REQ-014 SHALL have port stallreq_o, output, 1, IF stall request to ctrl.

Function
REQ-015 SHALL implement states IDLE, FETCH, HOLD and DRAIN; reset state IDLE.
REQ-016 IDLE SHALL hold ibus_req_o = 0 and move to FETCH on the next cycle unconditionally.
REQ-017 FETCH SHALL drive ibus_req_o = 1 with ibus_addr_o = {pc[31:2],2'b00}; request and address held stable until ack.
REQ-018 "Delivering" SHALL mean (FETCH & ack & !flush) | (HOLD & !flush); while delivering, if_pc = pc and if_inst = ack ? ibus_data_i : hold_inst (combinational).
REQ-019 When not delivering, if_pc and if_inst SHALL both be 0.
REQ-020 stallreq_o SHALL equal !delivering & !flush.
REQ-021 Delivering with stall[1] = NoStop SHALL advance the PC:
- pc <= branch target (pending or live) if one exists, else pc + 4 (mod 2^32 wrap);
- clear the pending branch;
- state FETCH.
REQ-022 FETCH & ack & stall[1] = Stop SHALL capture ibus_data_i into hold_inst and move to HOLD with ibus_req_o = 0; HOLD SHALL remain while stall[1] = Stop.
REQ-023 branch_flag_i = 1 when not advancing SHALL latch branch_target_addr_i into a pending register; the latest assertion wins.
REQ-024 flush SHALL have priority over branch, ack and stall. Response by state:
- FETCH & ack, or HOLD: pc <= new_pc, pending branch cleared, hold_inst discarded, state FETCH.
- FETCH & !ack: latch new_pc as redirect, go DRAIN.
REQ-025 DRAIN SHALL keep ibus_req_o = 1 at the old address until ack, discard that data, then set pc <= redirect and go FETCH.
REQ-026 A further flush in DRAIN SHALL overwrite the redirect; branch_flag_i SHALL be ignored in DRAIN.
REQ-027 Latency: ack on cycle N with stall[1] = NoStop presents the instruction on if_inst in cycle N and the next request address in cycle N+1.

Reset
REQ-028 rst = 0 at a clock edge SHALL force the following, regardless of any outstanding bus request:
- state IDLE; pc = `RESET_PC` (32'h0000_0000);
- pending branch, redirect and hold_inst cleared to 0.
REQ-029 During and immediately after reset, outputs SHALL be ibus_req_o = 0, ibus_addr_o = 0, if_pc = 0, if_inst = 0, stallreq_o = 1.

Structure
REQ-030 `RESET_PC`, the state encodings, `Stop`/`NoStop`, `RstEnable` and `ZeroWord` SHALL live in shared defines.v.
REQ-031 The block SHALL be a single module with no sub-modules; the state register, pc, pending branch, redirect and hold_inst are local registers.

Verification
REQ-032 Reset then zero-wait ack: addresses 0x0, 0x4, 0x8 on successive cycles; if_inst equals the data on ack cycles; stallreq_o = 0 on ack cycles.
REQ-033 Ack at 0x4 with stall[1] = 1 for 3 cycles: if_inst = held word and ibus_req_o = 0 for 3 cycles; then the next address is 0x8.
REQ-034 branch_flag_i = 1 with target 0x100 while the request at 0x8 waits 2 cycles: after ack, the next address is 0x100, not 0xC.
REQ-035 flush with new_pc = 0x180 while the request at 0x10 is unacked: DRAIN holds 0x10 until ack; data discarded (if_inst = 0); next address 0x180.
REQ-036 PC = 0xFFFF_FFFC delivered: next address 0x0 (wrap). Separately, rst = 0 mid-request: ibus_req_o = 0 next cycle, then a restart at 0x0.
